// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer.
//   ROB_* localparams : default geometry of rob_param
//   idx_w()           : entry-index width derived from the entry count
//   rob_entry_t       : entry record {finished, target, data} at default widths
package rob_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_WAYS   = 4;
  localparam int ROB_DATA_W = 16;
  localparam int ROB_REG_W  = 4;

  function automatic int idx_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic                  finished;
    logic [ROB_REG_W-1:0]  target;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_scan.sv
// Combinational in-order retire scan.
//   i_fin      : finished bit of every entry
//   i_tail     : oldest entry index
//   i_count    : occupied entries
//   o_ret_mask : lane k set when entry tail+k retires this cycle (thermometer)
//   o_ret_n    : number of retiring entries (0..WAYS)
module rob_retire_scan
  import rob_pkg::*;
#(
  parameter  int DEPTH = ROB_DEPTH,
  parameter  int WAYS  = ROB_WAYS,
  localparam int IDX_W = idx_w(DEPTH),
  localparam int CNT_W = IDX_W + 1,
  localparam int R_W   = $clog2(WAYS + 1)
) (
  input  logic [DEPTH-1:0] i_fin,
  input  logic [IDX_W-1:0] i_tail,
  input  logic [CNT_W-1:0] i_count,
  output logic [WAYS-1:0]  o_ret_mask,
  output logic [R_W-1:0]   o_ret_n
);

  // The run of finished entries stops at the first unfinished or unoccupied slot.
  always_comb begin
    logic w_run;
    w_run      = 1'b1;
    o_ret_mask = '0;
    o_ret_n    = '0;
    for (int k = 0; k < WAYS; k++) begin
      w_run         = w_run && (CNT_W'(k) < i_count) && i_fin[i_tail + IDX_W'(k)];
      o_ret_mask[k] = w_run;
      o_ret_n       = o_ret_n + R_W'(w_run);
    end
  end

endmodule

// File: rtl/rob_param.sv
// Parameterized multi-way reorder buffer.
//   clk, reset             : rising-edge clock, synchronous active-high reset
//   disp_valid/target      : per-lane dispatch request and destination register
//   disp_ready, disp_idx   : room for a full WAYS-wide dispatch; entry per lane
//   cdb_valid/idx/data     : completion broadcast
//   flush                  : drop every un-retired entry
//   ret_valid/target/data/idx : registered in-order retire pulses
//   count, full, empty     : occupancy
module rob_param
  import rob_pkg::*;
#(
  parameter  int DEPTH  = ROB_DEPTH,
  parameter  int WAYS   = ROB_WAYS,
  parameter  int DATA_W = ROB_DATA_W,
  parameter  int REG_W  = ROB_REG_W,
  localparam int IDX_W  = idx_w(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WAYS-1:0]              disp_valid,
  input  logic [WAYS-1:0][REG_W-1:0]   disp_target,
  output logic                         disp_ready,
  output logic [WAYS-1:0][IDX_W-1:0]   disp_idx,
  input  logic [WAYS-1:0]              cdb_valid,
  input  logic [WAYS-1:0][IDX_W-1:0]   cdb_idx,
  input  logic [WAYS-1:0][DATA_W-1:0]  cdb_data,
  input  logic                         flush,
  output logic [WAYS-1:0]              ret_valid,
  output logic [WAYS-1:0][REG_W-1:0]   ret_target,
  output logic [WAYS-1:0][DATA_W-1:0]  ret_data,
  output logic [WAYS-1:0][IDX_W-1:0]   ret_idx,
  output logic [IDX_W:0]               count,
  output logic                         full,
  output logic                         empty
);

  localparam int CNT_W = IDX_W + 1;
  localparam int R_W   = $clog2(WAYS + 1);

  // Same layout as rob_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic              finished;
    logic [REG_W-1:0]  target;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t                       r_ent [DEPTH];
  logic [IDX_W-1:0]             r_head, r_tail;
  logic [CNT_W-1:0]             r_count;
  logic [WAYS-1:0]              r_ret_valid;
  logic [WAYS-1:0][REG_W-1:0]   r_ret_target;
  logic [WAYS-1:0][DATA_W-1:0]  r_ret_data;
  logic [WAYS-1:0][IDX_W-1:0]   r_ret_idx;

  logic [DEPTH-1:0]             w_fin;
  logic [CNT_W-1:0]             w_pop;
  logic [CNT_W-1:0]             w_free;
  logic [WAYS-1:0]              w_cdb_ok;
  logic [WAYS-1:0][IDX_W-1:0]   w_ret_ptr;
  logic [WAYS-1:0]              w_ret_mask;
  logic [R_W-1:0]               w_ret_n;

  // Dispatch lanes are compacted: each valid lane takes the next free slot.
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < WAYS; k++) begin
      disp_idx[k] = r_head + w_pop[IDX_W-1:0];
      w_pop       = w_pop + CNT_W'(disp_valid[k]);
    end
  end

  assign w_free     = CNT_W'(DEPTH) - r_count;
  assign disp_ready = !flush && (w_free >= CNT_W'(WAYS));

  // An index is occupied when its distance from tail is below count.
  always_comb begin
    for (int k = 0; k < WAYS; k++) begin
      w_cdb_ok[k]  = cdb_valid[k] && ({1'b0, IDX_W'(cdb_idx[k] - r_tail)} < r_count);
      w_ret_ptr[k] = r_tail + IDX_W'(k);
    end
    for (int i = 0; i < DEPTH; i++) w_fin[i] = r_ent[i].finished;
  end

  rob_retire_scan #(.DEPTH(DEPTH), .WAYS(WAYS)) u_scan (
    .i_fin      (w_fin),
    .i_tail     (r_tail),
    .i_count    (r_count),
    .o_ret_mask (w_ret_mask),
    .o_ret_n    (w_ret_n)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_ret_valid  <= '0;
      r_ret_target <= '0;
      r_ret_data   <= '0;
      r_ret_idx    <= '0;
      for (int i = 0; i < DEPTH; i++) r_ent[i].finished <= 1'b0;
    end else if (flush) begin
      r_head      <= r_tail;
      r_count     <= '0;
      r_ret_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_ent[i].finished <= 1'b0;
    end else begin
      // Retire reads pre-edge entry state, so a same-cycle completion waits a cycle.
      for (int k = 0; k < WAYS; k++) begin
        r_ret_valid[k] <= w_ret_mask[k];
        if (w_ret_mask[k]) begin
          r_ret_target[k] <= r_ent[w_ret_ptr[k]].target;
          r_ret_data[k]   <= r_ent[w_ret_ptr[k]].data;
          r_ret_idx[k]    <= w_ret_ptr[k];
        end
      end
      if (disp_ready) begin
        for (int k = 0; k < WAYS; k++) begin
          if (disp_valid[k]) begin
            r_ent[disp_idx[k]].finished <= 1'b0;
            r_ent[disp_idx[k]].target   <= disp_target[k];
          end
        end
      end
      // Later lanes override earlier ones on a shared index.
      for (int k = 0; k < WAYS; k++) begin
        if (w_cdb_ok[k]) begin
          r_ent[cdb_idx[k]].finished <= 1'b1;
          r_ent[cdb_idx[k]].data     <= cdb_data[k];
        end
      end
      r_head  <= r_head + (disp_ready ? w_pop[IDX_W-1:0] : '0);
      r_tail  <= r_tail + IDX_W'(w_ret_n);
      r_count <= r_count + (disp_ready ? w_pop : '0) - CNT_W'(w_ret_n);
    end
  end

  assign ret_valid  = r_ret_valid;
  assign ret_target = r_ret_target;
  assign ret_data   = r_ret_data;
  assign ret_idx    = r_ret_idx;
  assign count      = r_count;
  assign full       = (r_count == CNT_W'(DEPTH));
  assign empty      = (r_count == '0);

endmodule

// File: tb/tb_rob_param.sv
module tb_rob_param;

  localparam int DEPTH  = 16;
  localparam int WAYS   = 4;
  localparam int DATA_W = 16;
  localparam int REG_W  = 4;
  localparam int IDX_W  = 4;

  logic                        clk = 1'b0;
  logic                        reset, flush;
  logic [WAYS-1:0]             disp_valid;
  logic [WAYS-1:0][REG_W-1:0]  disp_target;
  logic                        disp_ready;
  logic [WAYS-1:0][IDX_W-1:0]  disp_idx;
  logic [WAYS-1:0]             cdb_valid;
  logic [WAYS-1:0][IDX_W-1:0]  cdb_idx;
  logic [WAYS-1:0][DATA_W-1:0] cdb_data;
  logic [WAYS-1:0]             ret_valid;
  logic [WAYS-1:0][REG_W-1:0]  ret_target;
  logic [WAYS-1:0][DATA_W-1:0] ret_data;
  logic [WAYS-1:0][IDX_W-1:0]  ret_idx;
  logic [IDX_W:0]              count;
  logic                        full, empty;

  rob_param #(.DEPTH(DEPTH), .WAYS(WAYS), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset), .disp_valid(disp_valid), .disp_target(disp_target),
    .disp_ready(disp_ready), .disp_idx(disp_idx), .cdb_valid(cdb_valid),
    .cdb_idx(cdb_idx), .cdb_data(cdb_data), .flush(flush), .ret_valid(ret_valid),
    .ret_target(ret_target), .ret_data(ret_data), .ret_idx(ret_idx),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: in-order queue of live entries, oldest first.
  typedef struct { int idx; int tgt; bit fin; int dat; } ment_t;
  ment_t mq[$];
  int    m_tail = 0;
  bit [WAYS-1:0] m_rv = '0;
  int    m_ridx[WAYS], m_rdat[WAYS], m_rtgt[WAYS];

  task automatic idle();
    flush = 0; disp_valid = '0; disp_target = '0;
    cdb_valid = '0; cdb_idx = '0; cdb_data = '0;
  endtask

  // Check combinational outputs, advance model, clock, check registered outputs.
  task automatic cycle();
    bit rdy, rst_step;
    int head, pc, r;
    logic [WAYS-1:0][IDX_W-1:0] e_idx;
    ment_t e;
    #1;
    head = (m_tail + mq.size()) % DEPTH;
    rdy  = !flush && (DEPTH - mq.size() >= WAYS);
    pc   = 0;
    for (int k = 0; k < WAYS; k++) begin
      e_idx[k] = IDX_W'((head + pc) % DEPTH);
      if (disp_valid[k]) pc++;
    end
    chk("disp_ready", disp_ready, rdy);
    chk("disp_idx", disp_idx, e_idx);
    rst_step = reset;
    if (reset) begin
      mq.delete(); m_tail = 0; m_rv = '0;
      for (int k = 0; k < WAYS; k++) begin m_ridx[k] = 0; m_rdat[k] = 0; m_rtgt[k] = 0; end
    end else if (flush) begin
      mq.delete(); m_rv = '0;
    end else begin
      r = 0;
      while (r < WAYS && r < mq.size() && mq[r].fin) r++;
      for (int k = 0; k < WAYS; k++) begin
        m_rv[k] = (k < r);
        if (k < r) begin m_ridx[k] = mq[k].idx; m_rdat[k] = mq[k].dat; m_rtgt[k] = mq[k].tgt; end
      end
      for (int k = 0; k < WAYS; k++)
        if (cdb_valid[k])
          for (int j = 0; j < mq.size(); j++)
            if (mq[j].idx == int'(cdb_idx[k])) begin
              e = mq[j]; e.fin = 1; e.dat = int'(cdb_data[k]); mq[j] = e;
            end
      for (int k = 0; k < r; k++) void'(mq.pop_front());
      m_tail = (m_tail + r) % DEPTH;
      if (rdy) begin
        pc = 0;
        for (int k = 0; k < WAYS; k++)
          if (disp_valid[k]) begin
            e.idx = (head + pc) % DEPTH; e.tgt = int'(disp_target[k]); e.fin = 0; e.dat = 0;
            mq.push_back(e); pc++;
          end
      end
    end
    @(posedge clk); #1;
    chk("count", count, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == DEPTH);
    chk("ret_valid", ret_valid, m_rv);
    for (int k = 0; k < WAYS; k++)
      if (m_rv[k] || rst_step) begin
        chk("ret_idx", ret_idx[k], m_ridx[k]);
        chk("ret_data", ret_data[k], m_rdat[k]);
        chk("ret_target", ret_target[k], m_rtgt[k]);
      end
  endtask

  task automatic do_reset();
    idle(); reset = 1; cycle(); reset = 0;
  endtask

  typedef struct {
    logic [3:0]  dv; logic [15:0] dt; logic [3:0] cv; logic [15:0] ci; logic [63:0] cd; logic fl;
    logic        e_rdy; logic [15:0] e_didx; int e_cnt; logic [3:0] e_rv;
    logic [15:0] e_ridx; logic [63:0] e_rdat; logic [15:0] e_rtgt;
  } vec_t;
  vec_t tv[8];

  initial begin
    logic [15:0] m16, m64lo;
    logic [63:0] m64;
    m64lo = '0;
    idle(); reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("rst_ready", disp_ready, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_ret_valid", ret_valid, 0);

    // Dispatch, out-of-order completion, flush, duplicate/unoccupied completion.
    tv[0] = '{4'b1111, 16'h4321, 4'b0000, 16'h0000, 64'h0, 1'b0,
              1'b1, 16'h3210, 4, 4'b0000, 16'h0, 64'h0, 16'h0};
    tv[1] = '{4'b0000, 16'h0000, 4'b0111, 16'h0102, 64'h0000_000C_000B_000A, 1'b0,
              1'b1, 16'h4444, 4, 4'b0000, 16'h0, 64'h0, 16'h0};
    tv[2] = '{4'b0000, 16'h0000, 4'b0000, 16'h0000, 64'h0, 1'b0,
              1'b1, 16'h4444, 1, 4'b0111, 16'h0210, 64'h0000_000A_000C_000B, 16'h0321};
    tv[3] = '{4'b0000, 16'h0000, 4'b0000, 16'h0000, 64'h0, 1'b0,
              1'b1, 16'h4444, 1, 4'b0000, 16'h0, 64'h0, 16'h0};
    tv[4] = '{4'b1111, 16'h8765, 4'b0001, 16'h0003, 64'h000D, 1'b1,
              1'b0, 16'h7654, 0, 4'b0000, 16'h0, 64'h0, 16'h0};
    tv[5] = '{4'b0001, 16'h0005, 4'b0000, 16'h0000, 64'h0, 1'b0,
              1'b1, 16'h4443, 1, 4'b0000, 16'h0, 64'h0, 16'h0};
    tv[6] = '{4'b0000, 16'h0000, 4'b1011, 16'h3039, 64'h0077_0000_0055_0099, 1'b0,
              1'b1, 16'h4444, 1, 4'b0000, 16'h0, 64'h0, 16'h0};
    tv[7] = '{4'b0000, 16'h0000, 4'b0000, 16'h0000, 64'h0, 1'b0,
              1'b1, 16'h4444, 0, 4'b0001, 16'h0003, 64'h0077, 16'h0005};
    for (int i = 0; i < 8; i++) begin
      disp_valid = tv[i].dv; disp_target = tv[i].dt; cdb_valid = tv[i].cv;
      cdb_idx = tv[i].ci; cdb_data = tv[i].cd; flush = tv[i].fl;
      #1;
      chk("tv_ready", disp_ready, tv[i].e_rdy);
      chk("tv_disp_idx", disp_idx, tv[i].e_didx);
      cycle();
      chk("tv_count", count, tv[i].e_cnt);
      chk("tv_ret_valid", ret_valid, tv[i].e_rv);
      m16 = '0; m64 = '0;
      for (int k = 0; k < WAYS; k++)
        if (tv[i].e_rv[k]) begin m16[k*4 +: 4] = 4'hF; m64[k*16 +: 16] = 16'hFFFF; end
      chk("tv_ret_idx", ret_idx & m16, tv[i].e_ridx);
      chk("tv_ret_data", ret_data & m64, tv[i].e_rdat);
      chk("tv_ret_target", ret_target & m16, tv[i].e_rtgt);
    end
    idle();

    // Fill to 13: dispatch refused until one entry retires.
    do_reset();
    disp_valid = 4'b1111; disp_target = 16'h9876;
    repeat (3) cycle();
    disp_valid = 4'b0001; cycle();
    chk("fill_count13", count, 13);
    disp_valid = 4'b1111; #1;
    chk("fill_ready_low", disp_ready, 1'b0);
    cycle();
    chk("fill_hold13", count, 13);
    idle(); cdb_valid = 4'b0001; cdb_idx = '0; cdb_data = 16'h1234; cycle();
    idle(); cycle();
    chk("fill_count12", count, 12);
    chk("fill_ret1", ret_valid, 4'b0001);
    chk("fill_ready_high", disp_ready, 1'b1);

    // Wrap: park head/tail at 14 then dispatch across the end of the array.
    do_reset();
    disp_valid = 4'b1111; disp_target = 16'h2222;
    repeat (3) cycle();
    disp_valid = 4'b0011; cycle();
    chk("wrap_count14", count, 14);
    idle(); cdb_valid = 4'b1111; cdb_data = {16'h44, 16'h33, 16'h22, 16'h11};
    cdb_idx = 16'h3210; cycle();
    cdb_idx = 16'h7654; cycle();
    cdb_idx = 16'hBA98; cycle();
    cdb_valid = 4'b0011; cdb_idx = 16'h00DC; cycle();
    idle(); repeat (2) cycle();
    chk("wrap_drained", count, 0);
    disp_valid = 4'b1111; disp_target = 16'hDCBA; #1;
    chk("wrap_disp_idx", disp_idx, 16'h10FE);
    cycle();
    idle(); cdb_valid = 4'b1111; cdb_idx = 16'hEF01; cdb_data = {16'hA4, 16'hA3, 16'hA2, 16'hA1};
    cycle();
    idle(); cycle();
    chk("wrap_ret_valid", ret_valid, 4'b1111);
    chk("wrap_ret_idx", ret_idx, 16'h10FE);
    chk("wrap_ret_target", ret_target, 16'hDCBA);

    // Reset mid-flight with a retire pending and dispatch/completion active.
    do_reset();
    disp_valid = 4'b1111; disp_target = 16'h5555;
    repeat (2) cycle();
    idle(); cdb_valid = 4'b0011; cdb_idx = 16'h0010; cdb_data = 32'h00BB_00AA; cycle();
    chk("mid_count8", count, 8);
    reset = 1; disp_valid = 4'b1111; cdb_valid = 4'b1100; cdb_idx = 16'h3200; flush = 1;
    cycle();
    reset = 0; idle(); #1;
    chk("mid_ret_valid", ret_valid, 0);
    chk("mid_count", count, 0);
    chk("mid_empty", empty, 1'b1);
    chk("mid_full", full, 1'b0);
    chk("mid_ready", disp_ready, 1'b1);
    chk("mid_ret_data", ret_data, 64'h0);

    // Random traffic against the queue model.
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 39) == 0);
      disp_valid = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b0000;
      for (int k = 0; k < WAYS; k++) begin
        disp_target[k] = 4'($urandom);
        cdb_data[k]    = 16'($urandom);
        cdb_valid[k]   = 1'($urandom_range(0, 1));
        if (mq.size() > 0 && $urandom_range(0, 3) != 0)
          cdb_idx[k] = 4'(mq[$urandom_range(0, mq.size() - 1)].idx);
        else
          cdb_idx[k] = 4'($urandom);
      end
      cycle();
    end
    reset = 0; idle();
    if (m64lo != 0) chk("unused", m64lo, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
